// File: rtl/serv_mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 opcodes, FSM state encoding and opcode decode helpers.
package serv_mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_FIN  = 3'd2,
    ST_ACK  = 3'd3,
    ST_WAIT = 3'd4
  } mdu_state_e;

  // Divide-class opcodes (DIV, DIVU, REM, REMU) all have funct3[2] set.
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // Remainder opcodes (REM, REMU) within the divide class.
  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // rs1 is treated as signed.
  function automatic logic sa(input logic [2:0] op);
    case (op)
      MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: sa = 1'b1;
      default:                                sa = 1'b0;
    endcase
  endfunction

  // rs2 is treated as signed.
  function automatic logic sb(input logic [2:0] op);
    case (op)
      MDU_MULH, MDU_DIV, MDU_REM: sb = 1'b1;
      default:                    sb = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/serv_mdu_cneg.sv
// Width-parameterised conditional two's-complement negator.
module serv_mdu_cneg #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_a,
  output logic [W-1:0] o_y
);

  assign o_y = i_neg ? (~i_a + {{(W-1){1'b0}}, 1'b1}) : i_a;

endmodule

// File: rtl/serv_mdu_iter.sv
// Iterative radix-2 RV32M multiply/divide unit. Operands are reduced to
// magnitudes on capture, a shared 64-bit {hi, lo} register runs 32 shift-add
// or restoring shift-subtract steps, and the sign is restored in one fix-up
// cycle before a single-cycle ready pulse.
module serv_mdu_iter
  import serv_mdu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mdu_valid,
  input  logic [2:0]  i_mdu_opcode,
  input  logic [31:0] i_mdu_rs1,
  input  logic [31:0] i_mdu_rs2,
  output logic        o_mdu_ready,
  output logic [31:0] o_mdu_rd
);

  mdu_state_e  r_state, w_next;
  logic [4:0]  r_cnt, w_cnt_d;
  logic [2:0]  r_op, w_op_d;
  logic        r_a_neg, w_a_neg_d;
  logic        r_b_neg, w_b_neg_d;
  logic [31:0] r_a, w_a_d;
  logic [31:0] r_b, w_b_d;
  logic [31:0] r_hi, w_hi_d;
  logic [31:0] r_lo, w_lo_d;
  logic [31:0] w_rd_d;
  logic        w_ready_d;

  // Operand capture: magnitudes of the raw request operands.
  logic        w_cap_a_neg, w_cap_b_neg;
  logic [31:0] w_abs_a, w_abs_b;

  assign w_cap_a_neg = sa(i_mdu_opcode) & i_mdu_rs1[31];
  assign w_cap_b_neg = sb(i_mdu_opcode) & i_mdu_rs2[31];

  serv_mdu_cneg #(.W(32)) u_neg_a (.i_neg(w_cap_a_neg), .i_a(i_mdu_rs1), .o_y(w_abs_a));
  serv_mdu_cneg #(.W(32)) u_neg_b (.i_neg(w_cap_b_neg), .i_a(i_mdu_rs2), .o_y(w_abs_b));

  // One iteration step. Multiply: add multiplicand into hi when the
  // multiplier LSB (lo[0]) is set, then shift the 33-bit sum down into lo.
  // Divide: shift {rem, quo} left and trial-subtract; a set bit 32 of the
  // shifted remainder means it already exceeds any 32-bit divisor.
  logic [32:0] w_mul_sum, w_div_sh, w_div_diff;
  logic        w_div_ok;

  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : 33'd0);
  assign w_div_sh   = {r_hi, r_lo[31]};
  assign w_div_diff = w_div_sh - {1'b0, r_b};
  assign w_div_ok   = w_div_sh[32] | ~w_div_diff[32];

  // Sign fix-up: one 64-bit negator serves product, quotient and remainder.
  logic        w_fin_neg;
  logic [63:0] w_fin_in, w_fin_y;
  logic [31:0] w_fin_sel;

  assign w_fin_in  = !is_div(r_op) ? {r_hi, r_lo}
                   : {32'd0, (is_rem(r_op) ? r_hi : r_lo)};
  assign w_fin_neg = !is_div(r_op) ? (r_a_neg ^ r_b_neg)
                   : is_rem(r_op)  ? r_a_neg
                   : ((r_a_neg ^ r_b_neg) & (r_b != 32'd0));
  assign w_fin_sel = (is_div(r_op) || (r_op == MDU_MUL)) ? w_fin_y[31:0] : w_fin_y[63:32];

  serv_mdu_cneg #(.W(64)) u_neg_fin (.i_neg(w_fin_neg), .i_a(w_fin_in), .o_y(w_fin_y));

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: WAIT blocks a level-held valid from relaunching.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_mdu_valid) w_next = ST_RUN;
        else             w_next = ST_IDLE;
      end
      ST_RUN: begin
        if (r_cnt == 5'd31) w_next = ST_FIN;
        else                w_next = ST_RUN;
      end
      ST_FIN:  w_next = ST_ACK;
      ST_ACK:  w_next = ST_WAIT;
      ST_WAIT: begin
        if (i_mdu_valid) w_next = ST_WAIT;
        else             w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Per-state next values for the datapath and the registered outputs.
  always_comb begin
    w_cnt_d   = r_cnt;
    w_op_d    = r_op;
    w_a_neg_d = r_a_neg;
    w_b_neg_d = r_b_neg;
    w_a_d     = r_a;
    w_b_d     = r_b;
    w_hi_d    = r_hi;
    w_lo_d    = r_lo;
    w_rd_d    = o_mdu_rd;
    w_ready_d = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_mdu_valid) begin
          w_cnt_d   = 5'd0;
          w_op_d    = i_mdu_opcode;
          w_a_neg_d = w_cap_a_neg;
          w_b_neg_d = w_cap_b_neg;
          w_a_d     = w_abs_a;
          w_b_d     = w_abs_b;
          w_hi_d    = 32'd0;
          w_lo_d    = is_div(i_mdu_opcode) ? w_abs_a : w_abs_b;
        end else begin
          w_cnt_d = r_cnt;
        end
      end
      ST_RUN: begin
        w_cnt_d = r_cnt + 5'd1;
        if (is_div(r_op)) begin
          w_hi_d = w_div_ok ? w_div_diff[31:0] : w_div_sh[31:0];
          w_lo_d = {r_lo[30:0], w_div_ok};
        end else begin
          w_hi_d = w_mul_sum[32:1];
          w_lo_d = {w_mul_sum[0], r_lo[31:1]};
        end
      end
      ST_FIN: begin
        w_rd_d    = w_fin_sel;
        w_ready_d = 1'b1;
      end
      default: begin
        w_ready_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= 5'd0;
      r_op        <= 3'd0;
      r_a_neg     <= 1'b0;
      r_b_neg     <= 1'b0;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      o_mdu_rd    <= 32'd0;
      o_mdu_ready <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_d;
      r_op        <= w_op_d;
      r_a_neg     <= w_a_neg_d;
      r_b_neg     <= w_b_neg_d;
      r_a         <= w_a_d;
      r_b         <= w_b_d;
      r_hi        <= w_hi_d;
      r_lo        <= w_lo_d;
      o_mdu_rd    <= w_rd_d;
      o_mdu_ready <= w_ready_d;
    end
  end

endmodule

// File: tb/tb_serv_mdu_iter.sv
// Directed bench for serv_mdu_iter: a table of hand-computed results plus
// sequences for held valid, valid re-raise and mid-operation reset.
module tb_serv_mdu_iter;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [2:0]  opcode;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        ready;
  logic [31:0] rd;

  int n_cmp = 0;
  int n_err = 0;

  serv_mdu_iter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_mdu_valid  (valid),
    .i_mdu_opcode (opcode),
    .i_mdu_rs1    (rs1),
    .i_mdu_rs2    (rs2),
    .o_mdu_ready  (ready),
    .o_mdu_rd     (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Count ready pulses over n cycles with valid held; inputs already driven.
  task automatic watch(input int n, output int lat, output int pulses, output logic [31:0] res);
    lat = 0;
    pulses = 0;
    res = 32'd0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready === 1'b1) begin
        pulses++;
        if (lat == 0) begin
          lat = i;
          res = rd;
        end
      end
    end
  endtask

  initial begin
    int          lat, pulses;
    logic [31:0] res;

    vecs[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB}; // MUL
    vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000}; // MULH
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE}; // MULHU
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}; // MULHSU
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD}; // DIV -7/2
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF}; // REM -7/2
    vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'h0000000E}; // DIVU
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'h00000002}; // REMU
    vecs[8]  = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF}; // DIV /0
    vecs[9]  = '{3'd6, 32'd5,        32'd0,        32'h00000005}; // REM /0
    vecs[10] = '{3'd5, 32'h80000000, 32'd0,        32'hFFFFFFFF}; // DIVU /0
    vecs[11] = '{3'd7, 32'h80000000, 32'd0,        32'h80000000}; // REMU /0
    vecs[12] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000}; // DIV ovf
    vecs[13] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000}; // REM ovf
    vecs[14] = '{3'd1, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF}; // MULH -1*1
    vecs[15] = '{3'd3, 32'h80000000, 32'h00000002, 32'h00000001}; // MULHU
    vecs[16] = '{3'd0, 32'h00010000, 32'h00010000, 32'h00000000}; // MUL wrap
    vecs[17] = '{3'd5, 32'hFFFFFFFF, 32'h80000000, 32'h00000001}; // DIVU big
    vecs[18] = '{3'd7, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF}; // REMU big
    vecs[19] = '{3'd6, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF}; // REM -7/-2

    rst = 1'b1;
    valid = 1'b0;
    opcode = 3'd0;
    rs1 = 32'd0;
    rs2 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_rd", rd, 32'd0);
    rst = 1'b0;
    @(posedge clk);

    // Table: result, fixed latency and a single pulse with valid held 40 cycles.
    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      opcode = vecs[v].op;
      rs1 = vecs[v].a;
      rs2 = vecs[v].b;
      valid = 1'b1;
      watch(40, lat, pulses, res);
      check($sformatf("vec%0d_rd", v), res, vecs[v].exp);
      check($sformatf("vec%0d_latency", v), lat, 32'd34);
      check($sformatf("vec%0d_pulses", v), pulses, 32'd1);
      valid = 1'b0;
      repeat (2) @(posedge clk);
    end

    // Valid held high for 50 cycles: exactly one pulse at cycle 34.
    @(negedge clk);
    opcode = 3'd0;
    rs1 = 32'h00000007;
    rs2 = 32'hFFFFFFFD;
    valid = 1'b1;
    watch(50, lat, pulses, res);
    check("hold50_pulses", pulses, 32'd1);
    check("hold50_latency", lat, 32'd34);
    check("hold50_rd", res, 32'hFFFFFFEB);

    // Drop valid for one cycle, re-raise: a new operation 34 cycles later.
    valid = 1'b0;
    opcode = 3'd5;
    rs1 = 32'd100;
    rs2 = 32'd7;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b1;
    watch(40, lat, pulses, res);
    check("reraise_latency", lat, 32'd34);
    check("reraise_rd", res, 32'h0000000E);

    // Reset during RUN (counter 10) with valid held high throughout.
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    opcode = 3'd0;
    rs1 = 32'h00000007;
    rs2 = 32'hFFFFFFFD;
    valid = 1'b1;
    watch(11, lat, pulses, res);
    check("pre_reset_pulses", pulses, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_rd", rd, 32'd0);
    rst = 1'b0;
    watch(40, lat, pulses, res);
    check("post_reset_latency", lat, 32'd34);
    check("post_reset_rd", res, 32'hFFFFFFEB);
    check("post_reset_pulses", pulses, 32'd1);
    valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
